// File: rtl/alu8_pkg.sv
// Shared definitions for the 8-bit ALU: default width and the opcode encoding.
package alu8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_CLR   = 4'b0000,
    OP_PASSA = 4'b0001,
    OP_PASSB = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOT   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_AND   = 4'b0111,
    OP_NAND  = 4'b1000,
    OP_XNOR  = 4'b1001,
    OP_SHL   = 4'b1010,
    OP_SHR   = 4'b1011,
    OP_INC   = 4'b1100,
    OP_DEC   = 4'b1101,
    OP_SUB   = 4'b1110,
    OP_ADD   = 4'b1111
  } opcode_e;

endpackage

// File: rtl/alu8_datapath.sv
// Purely combinational ALU core: decodes the opcode and produces the result
// together with the carry / borrow / shifted-out flag.
module alu8_datapath
  import alu8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_opcode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_flag
);

  localparam logic [WIDTH:0] EXT_ONE = (WIDTH+1)'(1);

  // Arithmetic is done one bit wider so the top bit carries the carry/borrow.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc  = {1'b0, i_a} + EXT_ONE;
  assign w_dec  = {1'b0, i_a} - EXT_ONE;

  // Opcode decode; every encoding is covered so no X can reach the register.
  always_comb begin
    o_result = '0;
    o_flag   = 1'b0;
    unique case (opcode_e'(i_opcode))
      OP_CLR:   o_result = '0;
      OP_PASSA: o_result = i_a;
      OP_PASSB: o_result = i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_NOT:   o_result = ~i_a;
      OP_NOR:   o_result = ~(i_a | i_b);
      OP_OR:    o_result = i_a | i_b;
      OP_AND:   o_result = i_a & i_b;
      OP_NAND:  o_result = ~(i_a & i_b);
      OP_XNOR:  o_result = ~(i_a ^ i_b);
      OP_SHL: begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_flag   = i_a[WIDTH-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_flag   = i_a[0];
      end
      OP_INC: begin
        o_result = w_inc[WIDTH-1:0];
        o_flag   = w_inc[WIDTH];
      end
      OP_DEC: begin
        o_result = w_dec[WIDTH-1:0];
        o_flag   = w_dec[WIDTH];
      end
      OP_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_flag   = w_diff[WIDTH];
      end
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_flag   = w_sum[WIDTH];
      end
      default: begin
        o_result = '0;
        o_flag   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: the combinational core feeds an enable-gated output
// register that clears asynchronously on reset.
module alu_8bit
  import alu8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  logic [WIDTH-1:0] w_result;
  logic             w_flag;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  alu8_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .i_a      (a),
    .i_b      (b),
    .i_opcode (opcode),
    .o_result (w_result),
    .o_flag   (w_flag)
  );

  // Capture the core's result only on enabled edges; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_cout <= 1'b0;
    end else if (en) begin
      r_out  <= w_result;
      r_cout <= w_flag;
    end
  end

  assign out  = r_out;
  assign cout = r_cout;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: stimulus pushes hand-computed expectations,
// a monitor pops and compares after every enabled clock edge.
module tb_alu_8bit;

  typedef struct {
    logic [7:0] expOut;
    logic       expCout;
    string      name;
  } expect_t;

  logic       clk;
  logic       rstN;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       en;
  logic [3:0] opcode;
  logic [7:0] dutOut;
  logic       dutCout;

  expect_t expQ[$];
  int      testsRun  = 0;
  int      failCount = 0;

  alu_8bit #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rstN),
    .a      (opA),
    .b      (opB),
    .en     (en),
    .opcode (opcode),
    .out    (dutOut),
    .cout   (dutCout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared comparison routine used by both the stimulus and the monitor.
  task automatic checkOutput(input string name, input logic [7:0] gotOut,
                             input logic gotCout, input logic [7:0] expOut,
                             input logic expCout);
    testsRun++;
    if (gotOut !== expOut || gotCout !== expCout) begin
      failCount++;
      $display("[TB] FAIL %s: got out=%02h cout=%b, expected out=%02h cout=%b",
               name, gotOut, gotCout, expOut, expCout);
    end
  endtask

  // Issue one enabled operation and record what it should produce.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] va,
                               input logic [7:0] vb, input logic [7:0] expOut,
                               input logic expCout, input string name);
    expect_t item;
    @(negedge clk);
    opA    = va;
    opB    = vb;
    opcode = op;
    en     = 1'b1;
    item.expOut  = expOut;
    item.expCout = expCout;
    item.name    = name;
    expQ.push_back(item);
    @(negedge clk);
    en = 1'b0;
  endtask

  // Monitor: after each edge that captured (en high, reset released), pop and compare.
  initial begin
    logic    sampledEn;
    expect_t item;
    forever begin
      @(posedge clk);
      sampledEn = en && rstN;
      #1;
      if (sampledEn) begin
        if (expQ.size() == 0) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL unexpected_capture: got out=%02h cout=%b, expected no capture",
                   dutOut, dutCout);
        end else begin
          item = expQ.pop_front();
          checkOutput(item.name, dutOut, dutCout, item.expOut, item.expCout);
        end
      end
    end
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int waitCycles;
    rstN   = 1'b0;
    en     = 1'b0;
    opA    = 8'h00;
    opB    = 8'h00;
    opcode = 4'b0000;

    #3;
    checkOutput("reset_initial", dutOut, dutCout, 8'h00, 1'b0);

    @(negedge clk);
    rstN = 1'b1;

    // Preload 5A, then reset asynchronously between edges.
    applyStimulus(4'b0001, 8'h5A, 8'h00, 8'h5A, 1'b0, "preload_passa");
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("reset_async", dutOut, dutCout, 8'h00, 1'b0);

    // Enabled edge while reset is held must not capture.
    opA    = 8'hFF;
    opB    = 8'hFF;
    opcode = 4'b1111;
    en     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_held", dutOut, dutCout, 8'h00, 1'b0);
    @(negedge clk);
    en   = 1'b0;
    rstN = 1'b1;

    // First edge after release without enable keeps zero.
    @(posedge clk);
    #1;
    checkOutput("post_reset_no_en", dutOut, dutCout, 8'h00, 1'b0);

    applyStimulus(4'b1111, 8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");
    opA    = 8'h12;
    opB    = 8'h34;
    opcode = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("hold_after_add", dutOut, dutCout, 8'hFE, 1'b1);

    applyStimulus(4'b0110, 8'hCC, 8'h33, 8'hFF, 1'b0, "or_cc_33");
    applyStimulus(4'b0111, 8'hCC, 8'h33, 8'h00, 1'b0, "and_cc_33");
    applyStimulus(4'b0100, 8'hAA, 8'h0F, 8'h55, 1'b0, "not_aa");
    applyStimulus(4'b1110, 8'h00, 8'h01, 8'hFF, 1'b1, "sub_underflow");
    applyStimulus(4'b1110, 8'h05, 8'h03, 8'h02, 1'b0, "sub_05_03");
    applyStimulus(4'b1010, 8'h81, 8'h00, 8'h02, 1'b1, "shl_81");
    applyStimulus(4'b1011, 8'h01, 8'h00, 8'h00, 1'b1, "shr_01");
    applyStimulus(4'b1100, 8'hFF, 8'h00, 8'h00, 1'b1, "inc_ff");
    applyStimulus(4'b1101, 8'h00, 8'h00, 8'hFF, 1'b1, "dec_00");
    applyStimulus(4'b0000, 8'hA5, 8'h5A, 8'h00, 1'b0, "clr");
    applyStimulus(4'b0010, 8'h11, 8'h3C, 8'h3C, 1'b0, "passb_3c");
    applyStimulus(4'b0011, 8'hF0, 8'h3C, 8'hCC, 1'b0, "xor_f0_3c");
    applyStimulus(4'b0101, 8'h0F, 8'h30, 8'hC0, 1'b0, "nor_0f_30");
    applyStimulus(4'b1000, 8'hF0, 8'h3C, 8'hCF, 1'b0, "nand_f0_3c");
    applyStimulus(4'b1001, 8'hF0, 8'h3C, 8'h33, 1'b0, "xnor_f0_3c");
    applyStimulus(4'b1111, 8'h80, 8'h7F, 8'hFF, 1'b0, "add_no_carry");
    applyStimulus(4'b1100, 8'h7F, 8'h00, 8'h80, 1'b0, "inc_7f");
    applyStimulus(4'b1101, 8'h80, 8'h00, 8'h7F, 1'b0, "dec_80");
    applyStimulus(4'b1011, 8'hC2, 8'h00, 8'h61, 1'b0, "shr_c2");
    applyStimulus(4'b1010, 8'h41, 8'h00, 8'h82, 1'b0, "shl_41");

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit registered ALU: 16 operations selected by a 4-bit opcode on operands a and b.
- Result and carry/borrow flag are captured on a clock edge only when en is high; otherwise the outputs hold their last value.
- Sits as a datapath execution unit fed by a controller that pulses en once per operation.

Parameters:
- WIDTH, 8, operand/result width; all requirements below are stated for 8, and the bench only needs to cover 8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- en  input  1  operation enable; result captured at rising clk while high
- opcode  input  4  operation select
- out  output  WIDTH  registered result
- cout  output  1  registered carry/borrow/shifted-out flag

Behaviour:
- Reset: rst_n low forces out=0 and cout=0 immediately, independent of clk; both stay 0 while rst_n is low.
- Capture: on rising clk with rst_n high and en=1, out and cout load the combinational result of the current a, b and opcode. Latency is 1 cycle.
- Hold: en=0 means out and cout hold their values. a, b and opcode are don't-care when en=0.
- Opcode map (cout=0 unless stated):
  - 0000 CLR: out=0
  - 0001 PASSA: out=a
  - 0010 PASSB: out=b
  - 0011 XOR: a^b
  - 0100 NOT: ~a (b ignored)
  - 0101 NOR: ~(a|b)
  - 0110 OR: a|b
  - 0111 AND: a&b
  - 1000 NAND: ~(a&b)
  - 1001 XNOR: ~(a^b)
  - 1010 SHL: {a[6:0],0}, cout=a[7]
  - 1011 SHR (logical): {0,a[7:1]}, cout=a[0]
  - 1100 INC: a+1, cout=1 iff a=FF
  - 1101 DEC: a-1, cout=1 (borrow) iff a=00
  - 1110 SUB: a-b mod 256, cout=1 (borrow) iff a<b unsigned
  - 1111 ADD: a+b mod 256, cout=carry out of bit 7
- Arithmetic is unsigned, modulo 2^WIDTH with a 9-bit internal sum. No overflow or zero flags.
- Every opcode value is decoded; no X propagation is allowed for any opcode.
- Reset asserted mid-operation: the registers clear at once. The first capture after release needs en=1 at a rising edge.
- Inputs changing between edges have no effect on the outputs until the next enabled edge.

Decomposition:
- Package alu8_pkg holds the 4-bit opcode constants or enum (OP_CLR … OP_ADD) and WIDTH default.
- Sub-module alu8_datapath is purely combinational: a, b, opcode in; result and flag out.
- The top alu_8bit contains only the en-gated output register with async reset.

Test Plan:
- Reset: rst_n=0 with prior out=5A -> out=00, cout=0 immediately, without a clock edge.
- ADD: a=FF, b=FF, op=1111, en pulse -> out=FE, cout=1 one cycle later. Then en=0 with inputs changed -> out holds FE.
- OR / AND: a=CC, b=33, op=0110 -> out=FF, cout=0. Then op=0111 -> out=00, cout=0.
- NOT: a=AA, op=0100 -> out=55, cout=0.
- SUB underflow: a=00, b=01, op=1110 -> out=FF, cout=1. Then a=05, b=03 -> out=02, cout=0.
- Shift/inc/dec edges:
  - SHL a=81 -> 02, cout=1
  - SHR a=01 -> 00, cout=1
  - INC a=FF -> 00, cout=1
  - DEC a=00 -> FF, cout=1
  - CLR -> 00
